// File: rtl/ddu_step_ctrl_pkg.sv
// Shared debug/step-control package: controller state encodings, CPU control
// constants and the breakpoint compare helper.
package ddu_step_ctrl_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned PC_W    = 32;

   // Step/run controller states
   typedef enum logic [STATE_W-1:0] {
      ST_HALT      = 3'd0,
      ST_STEP_GO   = 3'd1,
      ST_STEP_WAIT = 3'd2,
      ST_RUN_GO    = 3'd3,
      ST_RUN       = 3'd4,
      ST_DRAIN     = 3'd5
   } state_e;

   // Multicycle CPU control constants (instruction fetch marks the boundary)
   localparam int unsigned      CPU_CTRL_W      = 4;
   localparam logic [3:0]       CPU_ST_FETCH    = 4'd0;
   localparam logic [3:0]       CPU_ST_DECODE   = 4'd1;
   localparam logic [PC_W-1:0]  CPU_RESET_PC    = '0;
   localparam logic [PC_W-1:0]  CPU_INSTR_BYTES = 32'd4;

   // Breakpoint hit: enabled, at an instruction boundary, PC on the target
   function automatic logic bp_match(input logic            fetch,
                                     input logic            bp_en,
                                     input logic [PC_W-1:0] pc,
                                     input logic [PC_W-1:0] bp_addr);
      return fetch && bp_en && (pc == bp_addr);
   endfunction

endpackage

// File: rtl/ddu_step_ctrl_if.sv
// Debug-unit <-> CPU/host bundle.
//   master: CPU/host side, drives fetch, pc, bp_en, bp_addr, cnt_clr
//   slave : step controller, drives cpu_en, halted, bp_hit, state, counters
interface ddu_step_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   import ddu_step_ctrl_pkg::*;

   logic             fetch;
   logic [PC_W-1:0]  pc;
   logic             bp_en;
   logic [PC_W-1:0]  bp_addr;
   logic             cnt_clr;
   logic             cpu_en;
   logic             halted;
   logic             bp_hit;
   state_e           state;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instr_cnt;

   modport master (
      output fetch, pc, bp_en, bp_addr, cnt_clr,
      input  cpu_en, halted, bp_hit, state, cycle_cnt, instr_cnt
   );

   modport slave (
      input  fetch, pc, bp_en, bp_addr, cnt_clr,
      output cpu_en, halted, bp_hit, state, cycle_cnt, instr_cnt
   );

endinterface

// File: rtl/ddu_step_ctrl_sync_debounce.sv
// 2-flop synchronizer + debouncer for a raw button level.
//   clk, rst_n : clock, async active-low reset
//   i_raw      : raw asynchronous level
//   o_rise     : 1-cycle pulse on each accepted 0->1 of the debounced level
module sync_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_rise
);

   localparam int unsigned   DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      r_sync;
   logic [1:0]      r_sync_vld;
   logic            r_level;
   logic            r_armed;
   logic            r_rise;
   logic [DB_W-1:0] r_cnt;
   logic            w_differ;
   logic            w_accept;

   assign w_differ = r_sync[1] ^ r_level;
   assign w_accept = w_differ && (r_cnt == DB_LAST);
   assign o_rise   = r_rise;

   // r_armed only sets once a genuine low has come through the synchronizer,
   // so a button held through reset cannot fire until released and re-pressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync     <= '0;
         r_sync_vld <= '0;
         r_level    <= 1'b0;
         r_armed    <= 1'b0;
         r_rise     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync     <= {r_sync[0], i_raw};
         r_sync_vld <= {r_sync_vld[0], 1'b1};
         if (r_sync_vld[1] && !r_sync[1])
            r_armed <= 1'b1;
         if (!w_differ || w_accept)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + DB_W'(1);
         if (w_accept)
            r_level <= r_sync[1];
         r_rise <= w_accept && r_sync[1] && r_armed;
      end
   end

endmodule

// File: rtl/ddu_step_ctrl.sv
// Single-step / run / breakpoint controller gating the CPU clock enable.
//   clk, rst_n : clock, async active-low reset
//   i_step     : raw single-step button level
//   i_cont     : raw run switch level (1 = run)
//   dbg        : slave side of ddu_step_ctrl_if (fetch/pc/bp in, cpu_en/status/counters out)
module ddu_step_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_step,
   input  logic           i_cont,
   ddu_step_ctrl_if.slave dbg
);
   import ddu_step_ctrl_pkg::*;

   logic [1:0]       r_cont_sync;
   logic             w_cont;
   logic             w_step_req;
   state_e           r_state;
   state_e           w_state_nxt;
   logic             w_cpu_en;
   logic             w_bp_set;
   logic             w_bp_match;
   logic             r_halted;
   logic             r_bp_hit;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instr_cnt;

   sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (i_step),
      .o_rise (w_step_req)
   );

   // Run switch needs no debounce, only synchronization
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cont_sync <= '0;
      else        r_cont_sync <= {r_cont_sync[0], i_cont};
   end
   assign w_cont = r_cont_sync[1];

   assign w_bp_match = bp_match(dbg.fetch, dbg.bp_en, dbg.pc, dbg.bp_addr);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_HALT;
      else        r_state <= w_state_nxt;
   end

   // Next state and clock enable
   always_comb begin
      w_state_nxt = r_state;
      w_cpu_en    = 1'b0;
      w_bp_set    = 1'b0;
      case (r_state)
         ST_HALT: begin
            if (w_cont)          w_state_nxt = ST_RUN_GO;
            else if (w_step_req) w_state_nxt = ST_STEP_GO;
         end
         ST_STEP_GO: begin
            w_cpu_en    = 1'b1;
            w_state_nxt = ST_STEP_WAIT;
         end
         ST_STEP_WAIT: begin
            w_cpu_en = !dbg.fetch;
            if (dbg.fetch) w_state_nxt = ST_HALT;
         end
         // No compare here so resuming from a breakpoint gets past it
         ST_RUN_GO: begin
            w_cpu_en    = 1'b1;
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_bp_match) begin
               w_bp_set    = 1'b1;
               w_state_nxt = ST_HALT;
            end else begin
               w_cpu_en = 1'b1;
               if (!w_cont) w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_cpu_en = !dbg.fetch;
            if (dbg.fetch) begin
               w_state_nxt = ST_HALT;
               w_bp_set    = w_bp_match;
            end
         end
         default: w_state_nxt = ST_HALT;
      endcase
   end

   // Status flags; bp_hit holds until the controller leaves HALT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halted <= 1'b1;
         r_bp_hit <= 1'b0;
      end else begin
         r_halted <= (w_state_nxt == ST_HALT);
         if (w_bp_set)
            r_bp_hit <= 1'b1;
         else if ((r_state == ST_HALT) && (w_state_nxt != ST_HALT))
            r_bp_hit <= 1'b0;
      end
   end

   // Enabled-cycle and retired-fetch counters; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else if (dbg.cnt_clr) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         if (w_cpu_en)              r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         if (w_cpu_en && dbg.fetch) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
   end

   assign dbg.cpu_en    = w_cpu_en;
   assign dbg.halted    = r_halted;
   assign dbg.bp_hit    = r_bp_hit;
   assign dbg.state     = r_state;
   assign dbg.cycle_cnt = r_cycle_cnt;
   assign dbg.instr_cnt = r_instr_cnt;

endmodule

// File: doc/ddu_step_ctrl.md
DDU_STEP_CTRL -- requirements
Module: ddu_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a new step-button level.
REQ-002 Parameter CNT_W, default 32: width of cycle_cnt and instr_cnt.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 step  input  1  raw single-step button level, asynchronous to clk.
REQ-006 cont  input  1  raw run switch level, asynchronous to clk; 1 = run continuously.
REQ-007 fetch  input  1  high while CPU control is in its instruction-fetch state, which marks the instruction boundary.
REQ-008 pc  input  32  CPU PC; address of the instruction being fetched when fetch=1.
REQ-009 bp_en  input  1  breakpoint enable.
REQ-010 bp_addr  input  32  breakpoint instruction address.
REQ-011 cnt_clr  input  1  synchronous clear of both counters.
REQ-012 cpu_en  output  1  clock enable to CPU registers, PC, IR, ALUout and control FSM; combinational from state and fetch.
REQ-013 halted  output  1  high when state is HALT.
REQ-014 bp_hit  output  1  sticky flag: halted on breakpoint.
REQ-015 state  output  3  current FSM state encoding.
REQ-016 cycle_cnt, instr_cnt  output  CNT_W each  enabled-cycle and retired-fetch counters.

Function
REQ-017 step and cont SHALL each pass through a 2-flop synchronizer; step SHALL additionally be debounced, with the debounced level taking the synchronized value only after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-018 step_req SHALL be a 1-cycle pulse on each 0->1 transition of the debounced step level.
REQ-019 States: HALT, STEP_GO, STEP_WAIT, RUN_GO, RUN, DRAIN.
REQ-020 HALT: cpu_en=0; on synchronized cont=1 go to RUN_GO; else on step_req go to STEP_GO; cont has priority.
REQ-021 STEP_GO: cpu_en=1 unconditionally for exactly 1 cycle, consuming the current fetch; then go to STEP_WAIT.
REQ-022 STEP_WAIT: cpu_en=~fetch; when fetch=1 go to HALT, parking the CPU at the next instruction boundary.
REQ-023 RUN_GO: cpu_en=1 for 1 cycle with breakpoint compare suppressed, so resume from a breakpoint proceeds; then go to RUN.
REQ-024 RUN: cpu_en=1, except when fetch=1, bp_en=1 and pc==bp_addr: then cpu_en=0, bp_hit<=1, go to HALT.
REQ-025 RUN with synchronized cont=0 and no breakpoint match: go to DRAIN (cpu_en=1 that cycle).
REQ-026 DRAIN: cpu_en=~fetch; when fetch=1 go to HALT; a breakpoint match here also sets bp_hit.
REQ-027 step_req SHALL be ignored in every state except HALT; it SHALL NOT be queued.
REQ-028 bp_hit SHALL clear on any transition out of HALT.
REQ-029 cycle_cnt SHALL increment on every cycle with cpu_en=1; instr_cnt SHALL increment on every cycle with cpu_en=1 and fetch=1.
REQ-030 Counters SHALL wrap modulo 2^CNT_W; cnt_clr SHALL take priority over increment in the same cycle.

Reset
REQ-031 rst_n low SHALL immediately force state=HALT, cpu_en=0, halted=1, bp_hit=0, counters=0, synchronizers and debounced level=0, and debounce counter=0, including mid-STEP or mid-RUN.
REQ-032 After release, a step held high through reset SHALL NOT produce step_req until it is released and pressed again.

Structure
REQ-033 State encodings (HALT=0, STEP_GO=1, STEP_WAIT=2, RUN_GO=3, RUN=4, DRAIN=5) SHALL reside in a shared package with the CPU control constants.
REQ-034 Synchronizer plus debouncer SHALL be one sub-module, sync_debounce, instantiated once for step; cont uses a bare 2-flop synchronizer.

Verification (DEBOUNCE_CYCLES=4, fetch model: 1 of every 4 enabled cycles)
REQ-035 Step press held 10 cycles from HALT -> cpu_en high for exactly 4 cycles beginning within 8 cycles of press, then HALT; instr_cnt=1, cycle_cnt=4.
REQ-036 Step glitch high for 2 cycles -> no step_req, cpu_en stays 0.
REQ-037 cont=1, bp_en=1, bp_addr=0x0000000C, program pc 0,4,8,C -> halted with pc=0x0C, bp_hit=1, instr_cnt=3; cont toggled 0->1 -> resumes past 0x0C, bp_hit=0.
REQ-038 cont dropped mid-instruction in RUN -> cpu_en stays 1 until next fetch, then HALT with fetch=1.
REQ-039 cycle_cnt preloaded by running to 0xFFFFFFFF, one more enabled cycle -> 0x00000000; cnt_clr with cpu_en=1 -> 0.
REQ-040 rst_n pulsed low during STEP_WAIT -> cpu_en=0 in the same cycle, state=HALT, counters=0.
